// File: rtl/cell_particle_fetch.sv
// rtl/cell_particle_fetch.sv - sequential cell-memory reader presenting particle positions as a valid/ready stream
module cell_particle_fetch #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int RD_LATENCY   = 1,
    parameter int BUF_DEPTH    = RD_LATENCY + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_id,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + RD_LATENCY + 1) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(PARTICLE_NUM);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt_max;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  sr_valid [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] sr_addr  [RD_LATENCY];
    logic                  sr_last  [RD_LATENCY];

    logic [DATA_WIDTH-1:0] fifo_data [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_id   [BUF_DEPTH];
    logic                  fifo_last [BUF_DEPTH];
    logic [PTR_W-1:0]      fifo_wr, fifo_rd;
    logic [OCC_W-1:0]      fifo_cnt;

    logic                  exit_valid, exit_last;
    logic [ADDR_WIDTH-1:0] exit_addr;
    logic                  fifo_empty, pop, store, unload;
    logic                  issue, last_issue, credit;
    logic [OCC_W-1:0]      inflight, occ_after;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ADDR_WIDTH-1:0] head_id;
    logic                  head_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign exit_valid = sr_valid[RD_LATENCY-1];
    assign exit_addr  = sr_addr[RD_LATENCY-1];
    assign exit_last  = sr_last[RD_LATENCY-1];
    assign fifo_empty = (fifo_cnt == '0);

    // The word leaving the read pipeline falls straight through when the buffer is empty
    assign head_data = fifo_empty ? mem_q     : fifo_data[fifo_rd];
    assign head_id   = fifo_empty ? exit_addr : fifo_id[fifo_rd];
    assign head_last = fifo_empty ? exit_last : fifo_last[fifo_rd];

    assign out_valid = !fifo_empty || exit_valid;
    assign out_data  = out_valid ? head_data : '0;
    assign out_id    = out_valid ? head_id   : '0;
    assign out_last  = out_valid ? head_last : 1'b0;
    assign pop       = out_valid && out_ready;
    assign store     = exit_valid && !(fifo_empty && pop);
    assign unload    = pop && !fifo_empty;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(sr_valid[i]);
        end
    end

    // Reads already committed (buffered or in flight) must never exceed buffer space
    assign occ_after  = fifo_cnt + inflight - OCC_W'(pop);
    assign credit     = (occ_after < OCC_W'(BUF_DEPTH));
    assign issue      = (state == S_FETCH) && credit;
    assign last_issue = issue && ({1'b0, rd_ptr} == cnt_max - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (particle_count == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && out_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rden    = issue;
        mem_address = issue ? rd_ptr : addr_q;
        mem_wren    = 1'b0;
        busy        = (state == S_FETCH) || (state == S_DRAIN);
        done        = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_max <= '0;
            rd_ptr  <= '0;
            addr_q  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                sr_valid[i] <= 1'b0;
                sr_addr[i]  <= '0;
                sr_last[i]  <= 1'b0;
            end
        end else begin
            if (state == S_IDLE && start && particle_count != '0) begin
                cnt_max <= (particle_count > MAX_CNT) ? MAX_CNT : particle_count;
                rd_ptr  <= '0;
            end else if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= rd_ptr;
            end
            sr_valid[0] <= issue;
            sr_addr[0]  <= rd_ptr;
            sr_last[0]  <= last_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_addr[i]  <= sr_addr[i-1];
                sr_last[i]  <= sr_last[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_id[i]   <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (store) begin
                fifo_data[fifo_wr] <= mem_q;
                fifo_id[fifo_wr]   <= exit_addr;
                fifo_last[fifo_wr] <= exit_last;
                fifo_wr            <= ptr_inc(fifo_wr);
            end
            if (unload) begin
                fifo_rd <= ptr_inc(fifo_rd);
            end
            fifo_cnt <= fifo_cnt + OCC_W'(store) - OCC_W'(unload);
        end
    end

endmodule

// File: tb/tb_cell_particle_fetch.sv
// tb/tb_cell_particle_fetch.sv - self-checking bench for cell_particle_fetch
module tb_cell_particle_fetch;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   particle_count = '0;
    logic [AW-1:0] mem_address;
    logic          mem_rden, mem_wren;
    logic [DW-1:0] mem_q = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_id;
    logic          out_last, busy, done;

    cell_particle_fetch #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW),
                          .RD_LATENCY(1), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .particle_count(particle_count),
        .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int i);
        return {32'(i + 2), 32'(i + 1), 32'(i)};
    endfunction

    logic [DW-1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = word(i);
    always @(posedge clk) if (mem_rden) mem_q <= mem[mem_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: expected ids of the current fetch and run statistics
    int t0 = 0;
    int exp_q[$];
    int issued, popped, done_cnt, busy_cnt, last_addr;
    int first_rden, first_valid, done_rel, last_pop_rel;
    bit saw_done;
    bit hold_pending = 1'b0;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_id;
    logic          hold_last;

    task automatic clear_stats();
        issued = 0; popped = 0; done_cnt = 0; busy_cnt = 0; last_addr = -1;
        first_rden = -1; first_valid = -1; done_rel = -1; last_pop_rel = -1;
        saw_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            int rel;
            int e;
            rel = cyc - t0;
            check(mem_wren == 1'b0, "mem_wren_low", mem_wren, 0);
            if (mem_rden) begin
                issued++;
                last_addr = mem_address;
                if (first_rden < 0) first_rden = rel;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                saw_done = 1'b1;
                if (done_rel < 0) done_rel = rel;
                check(busy == 1'b0, "busy_low_with_done", busy, 0);
            end
            if (hold_pending) begin
                check(out_valid && out_data == hold_data && out_id == hold_id && out_last == hold_last,
                      "stall_stable", {out_valid, out_id, out_last}, {1'b1, hold_id, hold_last});
            end
            if (out_valid && first_valid < 0) first_valid = rel;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", out_id, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(out_id == AW'(e), "out_id", out_id, e);
                    check(out_data == word(e), "out_data", out_data, word(e));
                    check(out_last == (exp_q.size() == 0), "out_last", out_last, exp_q.size() == 0);
                end
                popped++;
                if (out_last) last_pop_rel = rel;
            end
            check(issued - popped <= BD, "occupancy_bound", issued - popped, BD);
            hold_pending = out_valid && !out_ready;
            hold_data = out_data;
            hold_id   = out_id;
            hold_last = out_last;
        end
    end

    task automatic run(input int pc, input int mode, input int second_pc);
        int n;
        n = (pc > PN) ? PN : pc;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(i);
        ready_mode = mode;
        @(posedge clk); #2;
        clear_stats();
        particle_count = (AW+1)'(pc);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        if (second_pc > 0) begin
            @(posedge clk); #2;
            particle_count = (AW+1)'(second_pc);
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (saw_done) break;
        end
        repeat (5) @(posedge clk);
        check(saw_done, "done_timeout", saw_done, 1);
        check(done_cnt == 1, "done_count", done_cnt, 1);
        check(exp_q.size() == 0, "words_missing", exp_q.size(), 0);
        check(popped == n, "words_popped", popped, n);
        check(issued == n, "reads_issued", issued, n);
        if (n > 0) check(last_addr == n - 1, "last_address", last_addr, n - 1);
    endtask

    initial begin
        #1;
        check(mem_address == 0 && mem_rden == 0 && out_valid == 0 && out_data == 0 &&
              out_id == 0 && out_last == 0 && busy == 0 && done == 0,
              "reset_outputs", {mem_rden, out_valid, busy, done}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        clear_stats();

        // Basic fetch timing, pinned by hand
        run(5, 0, 0);
        check(first_rden == 1, "basic_first_rden", first_rden, 1);
        check(first_valid == 2, "basic_first_valid", first_valid, 2);
        check(last_pop_rel == 6, "basic_last_pop", last_pop_rel, 6);
        check(done_rel == 7, "basic_done_cycle", done_rel, 7);
        check(busy_cnt == 6, "basic_busy_cycles", busy_cnt, 6);

        run(8, 1, 0);

        run(0, 0, 0);
        check(done_rel == 1, "zero_done_cycle", done_rel, 1);
        check(first_valid == -1, "zero_no_valid", first_valid, -1);
        check(first_rden == -1, "zero_no_rden", first_rden, -1);
        check(busy_cnt == 0, "zero_no_busy", busy_cnt, 0);

        run(220, 0, 0);
        check(last_addr == 219, "full_last_addr", last_addr, 219);
        run(255, 1, 0);
        check(last_addr == 219, "clamp_last_addr", last_addr, 219);

        run(4, 0, 9);

        // Reset in the middle of a 10-particle fetch
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(i);
        ready_mode = 0;
        @(posedge clk); #2;
        clear_stats();
        particle_count = 10;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        while (cyc < t0 + 3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check(mem_address == 0 && mem_rden == 0 && out_valid == 0 && out_data == 0 &&
              out_id == 0 && out_last == 0 && busy == 0 && done == 0,
              "midreset_outputs", {mem_address, mem_rden, out_valid, out_id, busy, done}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        check(done_cnt == 0, "midreset_no_done", done_cnt, 0);
        run(10, 0, 0);
        check(first_valid == 2, "after_reset_first_valid", first_valid, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
